// File: rtl/etapa_ex_if.sv
// ID/EX -> EX -> EX/MEM bundle for the JOF32 execute stage.
// master drives the instruction bundle and observes the result; slave is the stage.
interface etapa_ex_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         flush;
  logic [4:0]   opcode_in;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] inmediate_in;
  logic [W-1:0] shamt_in;
  logic [3:0]   rd_in;
  logic [3:0]   rt_in;
  logic [1:0]   alu_sel_in;
  logic         dir_sl_in;
  logic         mem_wr_in;
  logic         reg_wr_in;
  logic         sel_wb_in;
  logic         sel_ld_in;

  logic         stall;
  logic         out_valid;
  logic [W-1:0] result;
  logic [W-1:0] store_data;
  logic         zero;
  logic         ovf;
  logic [3:0]   rd_out;
  logic [3:0]   rt_out;
  logic [4:0]   opcode_out;
  logic         mem_wr_out;
  logic         reg_wr_out;
  logic         sel_wb_out;
  logic         sel_ld_out;

  modport master (
    output in_valid, flush, opcode_in, in_a, in_b, inmediate_in, shamt_in,
           rd_in, rt_in, alu_sel_in, dir_sl_in, mem_wr_in, reg_wr_in,
           sel_wb_in, sel_ld_in,
    input  stall, out_valid, result, store_data, zero, ovf, rd_out, rt_out,
           opcode_out, mem_wr_out, reg_wr_out, sel_wb_out, sel_ld_out
  );

  modport slave (
    input  in_valid, flush, opcode_in, in_a, in_b, inmediate_in, shamt_in,
           rd_in, rt_in, alu_sel_in, dir_sl_in, mem_wr_in, reg_wr_in,
           sel_wb_in, sel_ld_in,
    output stall, out_valid, result, store_data, zero, ovf, rd_out, rt_out,
           opcode_out, mem_wr_out, reg_wr_out, sel_wb_out, sel_ld_out
  );
endinterface

// File: rtl/etapa_ex.sv
// JOF32 execute stage: single-cycle add/sub/AND, iterative one-bit-per-cycle shifter
// that holds the upstream pipeline with a registered stall while shifting.
module etapa_ex #(
  parameter int W = 32
) (
  input logic        clk,
  input logic        rst_n,
  etapa_ex_if.slave  ex
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_SHF = 2'b11;

  state_t       state_q, state_d;
  logic [W-1:0] acc_q, acc_d;
  logic [4:0]   cnt_q, cnt_d;
  logic         dir_q, dir_d;
  logic         stall_q, stall_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] result_q, result_d;
  logic [W-1:0] store_data_q, store_data_d;
  logic         zero_q, zero_d;
  logic         ovf_q, ovf_d;
  logic [3:0]   rd_q, rd_d;
  logic [3:0]   rt_q, rt_d;
  logic [4:0]   opcode_q, opcode_d;
  // {mem_wr, reg_wr, sel_wb, sel_ld}
  logic [3:0]   ctrl_q, ctrl_d;

  logic [W-1:0] op_b;
  logic [W-1:0] sum;
  logic [W-1:0] diff;
  logic [W-1:0] alu_r;
  logic         alu_ovf;
  logic [W-1:0] acc_shifted;
  logic [4:0]   shift_n;

  assign op_b        = ex.opcode_in[4] ? ex.inmediate_in : ex.in_b;
  assign sum         = ex.in_a + op_b;
  assign diff        = ex.in_a - op_b;
  assign shift_n     = ex.shamt_in[4:0];
  assign acc_shifted = dir_q ? (acc_q >> 1) : (acc_q << 1);

  // Single-cycle ALU; a shift only reaches this path when its length is zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    alu_r   = '0;
    alu_ovf = 1'b0;
    unique case (ex.alu_sel_in)
      ALU_ADD: begin
        alu_r   = sum;
        alu_ovf = (ex.in_a[W-1] == op_b[W-1]) && (sum[W-1] != ex.in_a[W-1]);
      end
      ALU_SUB: begin
        alu_r   = diff;
        alu_ovf = (ex.in_a[W-1] != op_b[W-1]) && (diff[W-1] != ex.in_a[W-1]);
      end
      ALU_AND: alu_r = ex.in_a & op_b;
      ALU_SHF: alu_r = ex.in_a;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    stall_d      = 1'b0;
    out_valid_d  = 1'b0;
    result_d     = result_q;
    store_data_d = store_data_q;
    zero_d       = zero_q;
    ovf_d        = ovf_q;
    rd_d         = rd_q;
    rt_d         = rt_q;
    opcode_d     = opcode_q;
    ctrl_d       = ctrl_q;

    // Flush wins over both acceptance and shift completion.
    if (ex.flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ex.in_valid) begin
            store_data_d = ex.in_b;
            rd_d         = ex.rd_in;
            rt_d         = ex.rt_in;
            opcode_d     = ex.opcode_in;
            ctrl_d       = {ex.mem_wr_in, ex.reg_wr_in, ex.sel_wb_in, ex.sel_ld_in};
            if ((ex.alu_sel_in == ALU_SHF) && (shift_n != 5'd0)) begin
              acc_d   = ex.in_a;
              cnt_d   = shift_n;
              dir_d   = ex.dir_sl_in;
              stall_d = 1'b1;
              state_d = SHIFT;
            end else begin
              result_d    = alu_r;
              zero_d      = (alu_r == '0);
              ovf_d       = alu_ovf;
              out_valid_d = 1'b1;
            end
          end
        end
        SHIFT: begin
          acc_d = acc_shifted;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            result_d    = acc_shifted;
            zero_d      = (acc_shifted == '0);
            ovf_d       = 1'b0;
            out_valid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            stall_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      stall_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      result_q     <= '0;
      store_data_q <= '0;
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
      rd_q         <= '0;
      rt_q         <= '0;
      opcode_q     <= '0;
      ctrl_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      stall_q      <= stall_d;
      out_valid_q  <= out_valid_d;
      result_q     <= result_d;
      store_data_q <= store_data_d;
      zero_q       <= zero_d;
      ovf_q        <= ovf_d;
      rd_q         <= rd_d;
      rt_q         <= rt_d;
      opcode_q     <= opcode_d;
      ctrl_q       <= ctrl_d;
    end
  end

  assign ex.stall      = stall_q;
  assign ex.out_valid  = out_valid_q;
  assign ex.result     = result_q;
  assign ex.store_data = store_data_q;
  assign ex.zero       = zero_q;
  assign ex.ovf        = ovf_q;
  assign ex.rd_out     = rd_q;
  assign ex.rt_out     = rt_q;
  assign ex.opcode_out = opcode_q;
  // Control fields must never leak out of an invalid slot.
  assign ex.mem_wr_out = out_valid_q & ctrl_q[3];
  assign ex.reg_wr_out = out_valid_q & ctrl_q[2];
  assign ex.sel_wb_out = out_valid_q & ctrl_q[1];
  assign ex.sel_ld_out = out_valid_q & ctrl_q[0];

endmodule

// File: tb/tb_etapa_ex.sv
// Directed bench for etapa_ex: vector table for single-cycle ops plus
// hand-written sequences for shifts, async reset, flush and gating.
module tb_etapa_ex;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  etapa_ex_if #(.W(32)) bus ();

  etapa_ex #(.W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ex    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic        imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] immv;
    logic [4:0]  shamt;
    logic [3:0]  rd;
    logic        mem_wr;
    logic        reg_wr;
    logic [31:0] exp_r;
    logic        exp_z;
    logic        exp_o;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input string name, input logic [1:0] sel, input logic imm,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] immv,
                              input logic [4:0] shamt, input logic [3:0] rd,
                              input logic mem_wr, input logic reg_wr,
                              input logic [31:0] exp_r, input logic exp_z, input logic exp_o);
    vec_t v;
    v.name = name; v.sel = sel; v.imm = imm; v.a = a; v.b = b; v.immv = immv;
    v.shamt = shamt; v.rd = rd; v.mem_wr = mem_wr; v.reg_wr = reg_wr;
    v.exp_r = exp_r; v.exp_z = exp_z; v.exp_o = exp_o;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.opcode_in = '0;
    bus.in_a = '0; bus.in_b = '0; bus.inmediate_in = '0; bus.shamt_in = '0;
    bus.rd_in = '0; bus.rt_in = '0; bus.alu_sel_in = '0; bus.dir_sl_in = 1'b0;
    bus.mem_wr_in = 1'b0; bus.reg_wr_in = 1'b0; bus.sel_wb_in = 1'b0; bus.sel_ld_in = 1'b0;
  endtask

  task automatic drive(input logic [1:0] sel, input logic imm, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] immv, input logic [4:0] shamt,
                       input logic dir, input logic [3:0] rd, input logic mem_wr, input logic reg_wr);
    bus.in_valid = 1'b1; bus.flush = 1'b0;
    bus.opcode_in = {imm, 2'b00, sel};
    bus.in_a = a; bus.in_b = b; bus.inmediate_in = immv; bus.shamt_in = {27'h5A5A5A5, shamt};
    bus.rd_in = rd; bus.rt_in = ~rd; bus.alu_sel_in = sel; bus.dir_sl_in = dir;
    bus.mem_wr_in = mem_wr; bus.reg_wr_in = reg_wr; bus.sel_wb_in = 1'b1; bus.sel_ld_in = 1'b1;
  endtask

  initial begin
    int stall_cnt;
    int pulses;
    int latency;
    logic [31:0] shift_res;

    errors = 0;
    checks = 0;

    vecs[0] = mk("add_ovf",   2'b00, 1'b0, 32'h7FFFFFFF, 32'h1,        32'h0,        5'd0, 4'h1, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1);
    vecs[1] = mk("subi_zero", 2'b01, 1'b1, 32'h5,        32'h1234,     32'h5,        5'd0, 4'h2, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0);
    vecs[2] = mk("add_wrap",  2'b00, 1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        5'd0, 4'h3, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0);
    vecs[3] = mk("sub_ovf",   2'b01, 1'b0, 32'h80000000, 32'h1,        32'h0,        5'd0, 4'h4, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1);
    vecs[4] = mk("and",       2'b10, 1'b0, 32'hF0F0F0F0, 32'h3C3C3C3C, 32'h0,        5'd0, 4'h5, 1'b1, 1'b1, 32'h30303030, 1'b0, 1'b0);
    vecs[5] = mk("add_negov", 2'b00, 1'b0, 32'h80000000, 32'h80000000, 32'h0,        5'd0, 4'h6, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1);
    vecs[6] = mk("shift0",    2'b11, 1'b0, 32'hDEADBEEF, 32'h11111111, 32'h0,        5'd0, 4'h7, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    vecs[7] = mk("andi_zero", 2'b10, 1'b1, 32'hFFFF0000, 32'hFFFFFFFF, 32'h0000FFFF, 5'd0, 4'h8, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0);
    vecs[8] = mk("sub_neg",   2'b01, 1'b0, 32'h3,        32'h5,        32'h0,        5'd0, 4'h9, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    vecs[9] = mk("subi_sel",  2'b01, 1'b1, 32'hA,        32'h1,        32'hFFFFFFFF, 5'd0, 4'hA, 1'b1, 1'b1, 32'hB,        1'b0, 1'b0);

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Async reset in the middle of a 10-bit shift.
    drive(2'b11, 1'b0, 32'h1234, 32'hCAFEF00D, 32'h0, 5'd10, 1'b0, 4'hC, 1'b1, 1'b1);
    tick();
    check("shift_accept_stall", {31'd0, bus.stall}, 32'd1);
    bus.in_valid = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_stall",      {31'd0, bus.stall},      32'd0);
    check("rst_out_valid",  {31'd0, bus.out_valid},  32'd0);
    check("rst_result",     bus.result,              32'd0);
    check("rst_store_data", bus.store_data,          32'd0);
    check("rst_flags",      {30'd0, bus.zero, bus.ovf}, 32'd0);
    check("rst_ids",        {19'd0, bus.opcode_out, bus.rd_out, bus.rt_out}, 32'd0);
    check("rst_ctrl",       {28'd0, bus.mem_wr_out, bus.reg_wr_out, bus.sel_wb_out, bus.sel_ld_out}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_no_pulse", {31'd0, bus.out_valid}, 32'd0);

    // Single-cycle vectors, back to back.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].sel, vecs[i].imm, vecs[i].a, vecs[i].b, vecs[i].immv, vecs[i].shamt,
            1'b0, vecs[i].rd, vecs[i].mem_wr, vecs[i].reg_wr);
      tick();
      check({vecs[i].name, "_result"},     bus.result,                  vecs[i].exp_r);
      check({vecs[i].name, "_zero"},       {31'd0, bus.zero},           {31'd0, vecs[i].exp_z});
      check({vecs[i].name, "_ovf"},        {31'd0, bus.ovf},            {31'd0, vecs[i].exp_o});
      check({vecs[i].name, "_valid"},      {31'd0, bus.out_valid},      32'd1);
      check({vecs[i].name, "_stall"},      {31'd0, bus.stall},          32'd0);
      check({vecs[i].name, "_reg_wr"},     {31'd0, bus.reg_wr_out},     {31'd0, vecs[i].reg_wr});
      check({vecs[i].name, "_mem_wr"},     {31'd0, bus.mem_wr_out},     {31'd0, vecs[i].mem_wr});
      check({vecs[i].name, "_store_data"}, bus.store_data,              vecs[i].b);
      check({vecs[i].name, "_rd_rt"},      {24'd0, bus.rd_out, bus.rt_out}, {24'd0, vecs[i].rd, ~vecs[i].rd});
      check({vecs[i].name, "_opcode"},     {27'd0, bus.opcode_out},     {27'd0, vecs[i].imm, 2'b00, vecs[i].sel});
    end

    // Gating: invalid slot drops control even if inputs carry them.
    drive(2'b00, 1'b0, 32'h1, 32'h1, 32'h0, 5'd0, 1'b0, 4'h1, 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    tick();
    check("gate_valid",  {31'd0, bus.out_valid},  32'd0);
    check("gate_mem_wr", {31'd0, bus.mem_wr_out}, 32'd0);
    check("gate_reg_wr", {31'd0, bus.reg_wr_out}, 32'd0);

    // Flush beats acceptance in IDLE.
    drive(2'b00, 1'b0, 32'h1, 32'h2, 32'h0, 5'd0, 1'b0, 4'h1, 1'b1, 1'b1);
    bus.flush = 1'b1;
    tick();
    check("flush_idle_valid", {31'd0, bus.out_valid}, 32'd0);
    idle_inputs();
    tick();

    // Left shift 1 << 31: 31 stall cycles, latency 32, one pulse.
    drive(2'b11, 1'b0, 32'h1, 32'h0, 32'h0, 5'd31, 1'b0, 4'h3, 1'b0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_a = 32'hFFFFFFFF;
    bus.dir_sl_in = 1'b1;
    stall_cnt = bus.stall ? 1 : 0;
    pulses = 0; latency = 0; shift_res = '0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.stall) stall_cnt++;
      if (bus.out_valid) begin
        pulses++;
        if (latency == 0) begin
          latency = k + 1;
          shift_res = bus.result;
        end
      end
    end
    check("shl_stall_cycles", stall_cnt, 32'd31);
    check("shl_latency",      latency,   32'd32);
    check("shl_pulses",       pulses,    32'd1);
    check("shl_result",       shift_res, 32'h80000000);

    // Right shift by 4 with an add held behind it in ID/EX.
    drive(2'b11, 1'b0, 32'h80000000, 32'h0, 32'h0, 5'd4, 1'b1, 4'h4, 1'b0, 1'b1);
    tick();
    drive(2'b00, 1'b0, 32'h2, 32'h3, 32'h0, 5'd0, 1'b0, 4'h5, 1'b0, 1'b1);
    latency = 0; shift_res = '0;
    for (int k = 1; k <= 10 && latency == 0; k++) begin
      tick();
      if (bus.out_valid) begin
        latency = k + 1;
        shift_res = bus.result;
      end
    end
    check("shr_latency", latency,   32'd5);
    check("shr_result",  shift_res, 32'h08000000);
    tick();
    check("held_add_valid",  {31'd0, bus.out_valid}, 32'd1);
    check("held_add_result", bus.result,             32'd5);
    check("held_add_rd",     {28'd0, bus.rd_out},    32'h5);
    check("held_add_stall",  {31'd0, bus.stall},     32'd0);
    idle_inputs();
    tick();

    // Flush on the 3rd cycle of a 10-bit shift.
    drive(2'b11, 1'b0, 32'h1, 32'h0, 32'h0, 5'd10, 1'b0, 4'h6, 1'b1, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_stall", {31'd0, bus.stall},     32'd0);
    check("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.out_valid) pulses++;
    end
    check("flush_no_pulse", pulses, 32'd0);
    drive(2'b00, 1'b0, 32'h10, 32'h20, 32'h0, 5'd0, 1'b0, 4'h7, 1'b0, 1'b1);
    tick();
    check("post_flush_valid",  {31'd0, bus.out_valid}, 32'd1);
    check("post_flush_result", bus.result,             32'h30);
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
